// File: rtl/mod_sel_ctrl_pkg.sv
// Shared types for the modulation select controller: FSM states, field widths
// and the packed {FREQ, PHASE, DUTY} select word.
package mod_sel_ctrl_pkg;

  localparam int unsigned FREQ_W  = 3;
  localparam int unsigned PHASE_W = 5;
  localparam int unsigned DUTY_W  = 4;
  localparam int unsigned SEL_W   = FREQ_W + PHASE_W + DUTY_W;

  typedef enum logic [2:0] {
    INIT,
    IDLE,
    PENDING,
    GUARD_PRE,
    APPLY,
    GUARD_POST
  } state_e;

  typedef struct packed {
    logic [FREQ_W-1:0]  freq;
    logic [PHASE_W-1:0] phase;
    logic [DUTY_W-1:0]  duty;
  } sel_word_t;

  function automatic logic [SEL_W-1:0] pack_sel(input sel_word_t w);
    return {w.freq, w.phase, w.duty};
  endfunction

  function automatic sel_word_t unpack_sel(input logic [SEL_W-1:0] b);
    sel_word_t w;
    {w.freq, w.phase, w.duty} = b;
    return w;
  endfunction

endpackage

// File: rtl/sel_debounce.sv
// Two-flop synchroniser plus debounce of a multi-bit switch word; the stable
// word only follows after DEBOUNCE_CYCLES consecutive equal synced samples.
module sel_debounce #(
  parameter int unsigned WIDTH           = 12,
  parameter int unsigned DEBOUNCE_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             stable_vld_o,
  output logic             stable_new_o
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 2);

  logic [WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [WIDTH-1:0] cand_q, cand_d, stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d, new_q, new_d;

  // Stable loads on the edge where the counter reaches DEBOUNCE_CYCLES-1.
  always_comb begin
    sync1_d  = raw_i;
    sync2_d  = sync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    vld_d    = vld_q;
    new_d    = 1'b0;
    if (cand_q != sync2_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else begin
      if (cnt_q < CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_LOAD) begin
        stable_d = cand_q;
        vld_d    = 1'b1;
        new_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      vld_q    <= 1'b0;
      new_q    <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      vld_q    <= vld_d;
      new_q    <= new_d;
    end
  end

  assign stable_o     = stable_q;
  assign stable_vld_o = vld_q;
  assign stable_new_o = new_q;

endmodule

// File: rtl/mod_sel_ctrl.sv
// Turns raw frequency/phase/duty switches into glitch-safe applied selects,
// updating only at period boundaries and gating CLK_EN around frequency moves.
module mod_sel_ctrl
  import mod_sel_ctrl_pkg::*;
#(
  parameter int unsigned NUM_FREQ        = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000,
  parameter int unsigned GUARD_CYCLES    = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 4096
) (
  input  logic               USER_CLOCK,
  input  logic               RESET_N,
  input  logic [FREQ_W-1:0]  RAW_FREQ_SEL,
  input  logic [PHASE_W-1:0] RAW_PHASE_SEL,
  input  logic [DUTY_W-1:0]  RAW_DUTY_SEL,
  input  logic               PERIOD_START,
  input  logic               ERR_CLR,
  output logic [FREQ_W-1:0]  FREQ_SEL,
  output logic [PHASE_W-1:0] PHASE_SEL,
  output logic [DUTY_W-1:0]  DUTY_SEL,
  output logic               CLK_EN,
  output logic               UPDATE,
  output logic               SEL_ERR
);

  localparam int unsigned      GCNT_W     = $clog2(GUARD_CYCLES + 1);
  localparam int unsigned      TMO_W      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GCNT_W-1:0] GCNT_LAST  = GCNT_W'(GUARD_CYCLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [FREQ_W:0]   NUM_FREQ_L = (FREQ_W + 1)'(NUM_FREQ);

  sel_word_t        raw_w, stable_w;
  logic [SEL_W-1:0] raw_bits, stable_bits;
  logic             stable_vld, stable_new, freq_ok_c, stable_ok_c;

  always_comb begin
    raw_w       = '{freq: RAW_FREQ_SEL, phase: RAW_PHASE_SEL, duty: RAW_DUTY_SEL};
    raw_bits    = pack_sel(raw_w);
    stable_w    = unpack_sel(stable_bits);
    freq_ok_c   = ({1'b0, stable_w.freq} < NUM_FREQ_L);
    stable_ok_c = stable_vld && freq_ok_c;
  end

  sel_debounce #(
    .WIDTH          (SEL_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk         (USER_CLOCK),
    .rst_n       (RESET_N),
    .raw_i       (raw_bits),
    .stable_o    (stable_bits),
    .stable_vld_o(stable_vld),
    .stable_new_o(stable_new)
  );

  state_e            state_q, state_d;
  sel_word_t         tgt_q, tgt_d, lat_q, lat_d, app_q, app_d;
  logic              tgt_vld_q, tgt_vld_d, fchg_q, fchg_d;
  logic              clk_en_q, clk_en_d, upd_q, upd_d, err_q, err_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    tgt_vld_d = tgt_vld_q;
    lat_d     = lat_q;
    app_d     = app_q;
    fchg_d    = fchg_q;
    clk_en_d  = clk_en_q;
    upd_d     = 1'b0;
    err_d     = err_q;
    gcnt_d    = gcnt_q;
    tmo_d     = tmo_q;

    // Target is the newest legal stable word; an illegal one only flags.
    if (stable_ok_c) begin
      tgt_d     = stable_w;
      tgt_vld_d = 1'b1;
    end
    if (ERR_CLR) err_d = 1'b0;
    if (stable_new && !freq_ok_c) err_d = 1'b1;

    case (state_q)
      INIT: begin
        clk_en_d = 1'b0;
        if (tgt_vld_q) begin
          lat_d   = tgt_q;
          fchg_d  = 1'b1;
          state_d = APPLY;
        end
      end
      IDLE: begin
        if (tgt_vld_q && (tgt_q != app_q)) begin
          tmo_d   = '0;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (tgt_q == app_q) begin
          state_d = IDLE;
        end else if (PERIOD_START || (tmo_q == TMO_LAST)) begin
          lat_d = tgt_q;
          if (tgt_q.freq != app_q.freq) begin
            fchg_d   = 1'b1;
            clk_en_d = 1'b0;
            gcnt_d   = '0;
            state_d  = GUARD_PRE;
          end else begin
            fchg_d  = 1'b0;
            state_d = APPLY;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      GUARD_PRE: begin
        if (gcnt_q == GCNT_LAST) state_d = APPLY;
        else                     gcnt_d  = gcnt_q + GCNT_W'(1);
      end
      APPLY: begin
        app_d = lat_q;
        upd_d = 1'b1;
        if (fchg_q) begin
          clk_en_d = 1'b0;
          gcnt_d   = '0;
          state_d  = GUARD_POST;
        end else begin
          state_d = IDLE;
        end
      end
      GUARD_POST: begin
        if (gcnt_q == GCNT_LAST) begin
          clk_en_d = 1'b1;
          state_d  = IDLE;
        end else begin
          gcnt_d = gcnt_q + GCNT_W'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge USER_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= INIT;
      tgt_q     <= '0;
      tgt_vld_q <= 1'b0;
      lat_q     <= '0;
      app_q     <= '0;
      fchg_q    <= 1'b0;
      clk_en_q  <= 1'b0;
      upd_q     <= 1'b0;
      err_q     <= 1'b0;
      gcnt_q    <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      tgt_vld_q <= tgt_vld_d;
      lat_q     <= lat_d;
      app_q     <= app_d;
      fchg_q    <= fchg_d;
      clk_en_q  <= clk_en_d;
      upd_q     <= upd_d;
      err_q     <= err_d;
      gcnt_q    <= gcnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign FREQ_SEL  = app_q.freq;
  assign PHASE_SEL = app_q.phase;
  assign DUTY_SEL  = app_q.duty;
  assign CLK_EN    = clk_en_q;
  assign UPDATE    = upd_q;
  assign SEL_ERR   = err_q;

endmodule

// File: tb/tb_mod_sel_ctrl.sv
// Directed bench for mod_sel_ctrl: stimulus pushes expected applied words,
// a monitor pops and compares them on every UPDATE pulse.
module tb_mod_sel_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] raw_f;
  logic [4:0] raw_p;
  logic [3:0] raw_d;
  logic       ps, ec;
  logic [2:0] freq_sel;
  logic [4:0] phase_sel;
  logic [3:0] duty_sel;
  logic       clk_en, upd, sel_err;

  typedef struct {
    int f;
    int p;
    int d;
    int en;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_upd  = 0;

  always #5 clk = ~clk;

  mod_sel_ctrl #(
    .NUM_FREQ       (3),
    .DEBOUNCE_CYCLES(4),
    .GUARD_CYCLES   (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .USER_CLOCK   (clk),
    .RESET_N      (rst_n),
    .RAW_FREQ_SEL (raw_f),
    .RAW_PHASE_SEL(raw_p),
    .RAW_DUTY_SEL (raw_d),
    .PERIOD_START (ps),
    .ERR_CLR      (ec),
    .FREQ_SEL     (freq_sel),
    .PHASE_SEL    (phase_sel),
    .DUTY_SEL     (duty_sel),
    .CLK_EN       (clk_en),
    .UPDATE       (upd),
    .SEL_ERR      (sel_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  // Scoreboard monitor: each UPDATE pulse must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && upd) begin
      n_upd++;
      if (exp_q.size() == 0) begin
        chk("unexpected_update", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("upd_freq",   int'(freq_sel),  e.f);
        chk("upd_phase",  int'(phase_sel), e.p);
        chk("upd_duty",   int'(duty_sel),  e.d);
        chk("upd_clk_en", int'(clk_en),    e.en);
      end
    end
  end

  task automatic wait_upd(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!upd && n < max);
    if (!upd) chk("update_timeout", 0, 1);
  endtask

  task automatic push(input int f, input int p, input int d, input int en);
    exp_t e;
    e.f = f; e.p = p; e.d = d; e.en = en;
    exp_q.push_back(e);
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_freq"},   int'(freq_sel),  0);
    chk({pfx, "_phase"},  int'(phase_sel), 0);
    chk({pfx, "_duty"},   int'(duty_sel),  0);
    chk({pfx, "_clk_en"}, int'(clk_en),    0);
    chk({pfx, "_update"}, int'(upd),       0);
    chk({pfx, "_err"},    int'(sel_err),   0);
  endtask

  initial begin
    int n, base;
    logic en_ok;
    rst_n = 1'b0; raw_f = 3'd1; raw_p = 5'd5; raw_d = 4'd8; ps = 1'b0; ec = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");

    // Power-up apply from INIT without PERIOD_START
    push(1, 5, 8, 0);
    rst_n = 1'b1;
    wait_upd(40, n);
    chk("init_latency", n, 9);
    @(negedge clk); chk("init_guard_a", int'(clk_en), 0);
    @(negedge clk); chk("init_guard_b", int'(clk_en), 0);
    @(negedge clk); chk("init_en_on", int'(clk_en), 1);

    // Duty-only change applied on PERIOD_START, CLK_EN untouched
    base = n_upd; en_ok = 1'b1;
    raw_d = 4'd10;
    push(1, 5, 10, 1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!clk_en) en_ok = 1'b0;
    end
    ps = 1'b1;
    @(negedge clk); ps = 1'b0;
    chk("duty_hold", int'(duty_sel), 8);
    @(negedge clk);
    chk("duty_apply", int'(duty_sel), 10);
    chk("duty_update", int'(upd), 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (!clk_en) en_ok = 1'b0;
    end
    chk("duty_en_stays", int'(en_ok), 1);
    chk("duty_upd_count", n_upd - base, 1);

    // Frequency change: guard before and after
    raw_f = 3'd2;
    push(2, 5, 10, 0);
    repeat (10) @(negedge clk);
    ps = 1'b1;
    @(negedge clk); ps = 1'b0;
    chk("fpre_en_off", int'(clk_en), 0);
    repeat (3) @(negedge clk);
    chk("fpre_hold", int'(freq_sel), 1);
    chk("fpre_en_low", int'(clk_en), 0);
    @(negedge clk);
    chk("fapply_freq", int'(freq_sel), 2);
    chk("fapply_update", int'(upd), 1);
    repeat (2) @(negedge clk);
    chk("fpost_en_low", int'(clk_en), 0);
    @(negedge clk);
    chk("fpost_en_on", int'(clk_en), 1);

    // Short glitch to a legal code must be ignored
    base = n_upd;
    raw_f = 3'd0;
    repeat (2) @(negedge clk);
    raw_f = 3'd2;
    repeat (20) @(negedge clk);
    chk("glitch_upd_count", n_upd - base, 0);
    chk("glitch_freq", int'(freq_sel), 2);
    chk("glitch_err", int'(sel_err), 0);

    // Illegal frequency code: error flagged, selects hold
    raw_f = 3'd5;
    repeat (12) @(negedge clk);
    chk("bad_err_set", int'(sel_err), 1);
    chk("bad_freq_hold", int'(freq_sel), 2);
    chk("bad_phase_hold", int'(phase_sel), 5);
    chk("bad_duty_hold", int'(duty_sel), 10);
    ec = 1'b1;
    @(negedge clk); ec = 1'b0;
    chk("bad_err_clr", int'(sel_err), 0);
    raw_f = 3'd2;
    repeat (12) @(negedge clk);
    chk("bad_upd_count", n_upd - base, 0);
    chk("bad_err_stays_clr", int'(sel_err), 0);

    // Phase change with no period boundary: forced by timeout
    raw_p = 5'd9;
    push(2, 9, 10, 1);
    wait_upd(60, n);
    chk("tmo_latency", n, 25);
    repeat (3) @(negedge clk);

    // Frequency change, then reset in the middle of GUARD_POST
    raw_f = 3'd0;
    push(0, 9, 10, 0);
    repeat (10) @(negedge clk);
    ps = 1'b1;
    @(negedge clk); ps = 1'b0;
    wait_upd(20, n);
    chk("f0_apply_delay", n, 4);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    push(0, 9, 10, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_upd(40, n);
    chk("reinit_latency", n, 9);
    repeat (2) @(negedge clk);
    chk("reinit_guard", int'(clk_en), 0);
    @(negedge clk);
    chk("reinit_en_on", int'(clk_en), 1);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
